// File: rtl/alu_pkg.sv
// Shared execute-stage definitions used by the divider and the MAC-side logic.
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shift;
  logic           w_ge;

  // The partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits
  // and a non-negative trial difference is equivalent to shift >= divisor.
  assign w_shift = {i_rem, i_bit};
  assign w_ge    = (w_shift >= {1'b0, i_divisor});
  assign o_q_bit = w_ge;
  assign o_rem   = w_ge ? WIDTH'(w_shift - {1'b0, i_divisor}) : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned iterative divider with start/busy handshake and one-cycle done pulse.
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow_flag,
  output logic             zero_flag,
  output logic             negative_flag
);

  localparam int unsigned     CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state;
  logic [WIDTH-1:0] r_a, r_b, r_dvd, r_dvs, r_rem;
  logic             r_sgn, r_sign_q, r_sign_r;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_rem_nxt, w_q_fix, w_r_fix;
  logic             w_q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_dvd[WIDTH-1]),
    .i_divisor(r_dvs),
    .o_rem    (w_rem_nxt),
    .o_q_bit  (w_q_bit)
  );

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign w_q_fix = r_sign_q ? -r_dvd : r_dvd;
  assign w_r_fix = r_sign_r ? -r_rem : r_rem;

  // r_dvd starts as the dividend magnitude and is shifted out MSB-first while quotient bits enter at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_rem         <= '0;
      r_sgn         <= 1'b0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_cnt         <= '0;
      quotient      <= '0;
      remainder     <= '0;
      div_by_zero   <= 1'b0;
      overflow_flag <= 1'b0;
      zero_flag     <= 1'b0;
      negative_flag <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a           <= dividend;
            r_b           <= divisor;
            r_sgn         <= is_signed;
            div_by_zero   <= 1'b0;
            overflow_flag <= 1'b0;
            if (divisor == '0) begin
              quotient      <= '1;
              remainder     <= dividend;
              div_by_zero   <= 1'b1;
              zero_flag     <= 1'b0;
              negative_flag <= 1'b1;
              r_state       <= DONE;
            end else begin
              r_state <= PREP;
            end
          end
        end
        PREP: begin
          r_dvd    <= (r_sgn && r_a[WIDTH-1]) ? -r_a : r_a;
          r_dvs    <= (r_sgn && r_b[WIDTH-1]) ? -r_b : r_b;
          r_sign_q <= r_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_sign_r <= r_sgn & r_a[WIDTH-1];
          r_rem    <= '0;
          r_cnt    <= '0;
          r_state  <= ITER;
        end
        ITER: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          quotient      <= w_q_fix;
          remainder     <= w_r_fix;
          zero_flag     <= (w_q_fix == '0);
          negative_flag <= w_q_fix[WIDTH-1];
          overflow_flag <= r_sgn && (r_a == MIN_VAL) && (r_b == '1);
          r_state       <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results come from native SV division semantics.
module tb_seq_divider;

  localparam int unsigned W = 32;
  localparam int unsigned LAT = W + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  dividend, divisor;
  logic          busy, done;
  logic [W-1:0]  quotient, remainder;
  logic          div_by_zero, overflow_flag, zero_flag, negative_flag;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [3:0]   f;   // {div_by_zero, overflow, zero, negative}
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_signed    (is_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .busy         (busy),
    .done         (done),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .overflow_flag(overflow_flag),
    .zero_flag    (zero_flag),
    .negative_flag(negative_flag)
  );

  always #5 clk = ~clk;

  wire [3:0] flags = {div_by_zero, overflow_flag, zero_flag, negative_flag};

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    exp_t e;
    logic signed [W-1:0] sa, sb_;
    logic [W-1:0] minv;
    logic ovf;
    minv = {1'b1, {(W-1){1'b0}}};
    sa = a;
    sb_ = b;
    ovf = 1'b0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.f = 4'b1001; e.lat = 0;
      return e;
    end
    if (sgn) begin
      if (a == minv && b == '1) begin
        e.q = minv; e.r = '0; ovf = 1'b1;
      end else begin
        e.q = sa / sb_;
        e.r = sa % sb_;
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.f = {1'b0, ovf, (e.q == '0), e.q[W-1]};
    e.lat = LAT;
    return e;
  endfunction

  // Drive one start from 1ns after an edge; returns 1ns after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input bit push);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) sb.push_back(model(a, b, sgn));
  endtask

  task automatic wait_done(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n <= budget) begin
      if (done) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, quotient, remainder, flags} !== '0) begin
      bad++;
      $display("FAIL reset_outputs act=%h exp=0", {busy, done, quotient, remainder, flags});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    int n; bit ok; exp_t e;
    launch(32'd100, 32'd7, 1'b0, 1'b1);
    wait_done(60, n, ok);
    e = sb.pop_front();
    total++;
    if (!ok) begin bad++; $display("FAIL unsigned_timeout act=none exp=done"); end
    total++; if (n !== e.lat) begin bad++; $display("FAIL unsigned_lat act=%0d exp=%0d", n, e.lat); end
    total++; if (quotient !== e.q) begin bad++; $display("FAIL unsigned_q act=%h exp=%h", quotient, e.q); end
    total++; if (remainder !== e.r) begin bad++; $display("FAIL unsigned_r act=%h exp=%h", remainder, e.r); end
    total++; if (flags !== e.f) begin bad++; $display("FAIL unsigned_flags act=%b exp=%b", flags, e.f); end
    @(posedge clk); #1;
    total++;
    if ({busy, done} !== 2'b00 || quotient !== e.q) begin
      bad++; $display("FAIL unsigned_after act=%b/%h exp=00/%h", {busy, done}, quotient, e.q);
    end
  endtask

  task automatic test_signed;
    logic [W-1:0] ta [5];
    logic [W-1:0] tb [5];
    logic         ts [5];
    int n; bit ok; exp_t e;
    ta = '{-32'sd7, 32'd7, -32'sd100, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    tb = '{32'd2, -32'sd2, -32'sd9, 32'd3, 32'h8000_0000};
    ts = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      launch(ta[i], tb[i], ts[i], 1'b1);
      wait_done(60, n, ok);
      e = sb.pop_front();
      total++; if (!ok || n !== e.lat) begin bad++; $display("FAIL signed%0d_lat act=%0d exp=%0d", i, n, e.lat); end
      total++; if (quotient !== e.q) begin bad++; $display("FAIL signed%0d_q act=%h exp=%h", i, quotient, e.q); end
      total++; if (remainder !== e.r) begin bad++; $display("FAIL signed%0d_r act=%h exp=%h", i, remainder, e.r); end
      total++; if (flags !== e.f) begin bad++; $display("FAIL signed%0d_flags act=%b exp=%b", i, flags, e.f); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero;
    int n; bit ok; exp_t e;
    launch(32'h0000_1234, 32'h0, 1'b0, 1'b1);
    wait_done(60, n, ok);
    e = sb.pop_front();
    total++; if (!ok || n !== e.lat) begin bad++; $display("FAIL dbz_lat act=%0d exp=%0d", n, e.lat); end
    total++; if (quotient !== e.q) begin bad++; $display("FAIL dbz_q act=%h exp=%h", quotient, e.q); end
    total++; if (remainder !== e.r) begin bad++; $display("FAIL dbz_r act=%h exp=%h", remainder, e.r); end
    total++; if (flags !== e.f) begin bad++; $display("FAIL dbz_flags act=%b exp=%b", flags, e.f); end
    @(posedge clk); #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL dbz_after act=%b exp=00", {busy, done}); end
  endtask

  task automatic test_overflow;
    int n; bit ok; exp_t e;
    for (int s = 1; s >= 0; s--) begin
      launch(32'h8000_0000, 32'hFFFF_FFFF, s[0], 1'b1);
      // Accepting edge must clear the sticky flags of the previous result.
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL ovf%0d_clear act=%b exp=0", s, div_by_zero); end
      wait_done(60, n, ok);
      e = sb.pop_front();
      total++; if (!ok || n !== e.lat) begin bad++; $display("FAIL ovf%0d_lat act=%0d exp=%0d", s, n, e.lat); end
      total++; if (quotient !== e.q) begin bad++; $display("FAIL ovf%0d_q act=%h exp=%h", s, quotient, e.q); end
      total++; if (remainder !== e.r) begin bad++; $display("FAIL ovf%0d_r act=%h exp=%h", s, remainder, e.r); end
      total++; if (flags !== e.f) begin bad++; $display("FAIL ovf%0d_flags act=%b exp=%b", s, flags, e.f); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start;
    int n, pulses; bit ok; exp_t e;
    pulses = 0;
    launch(-32'sd1000, 32'd9, 1'b1, 1'b1);
    repeat (9) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    dividend = 32'd5; divisor = 32'd0; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (done) pulses++;
    wait_done(60, n, ok);
    e = sb.pop_front();
    total++; if (!ok || n + 10 !== e.lat) begin bad++; $display("FAIL ignore_lat act=%0d exp=%0d", n + 10, e.lat); end
    total++; if (quotient !== e.q) begin bad++; $display("FAIL ignore_q act=%h exp=%h", quotient, e.q); end
    total++; if (remainder !== e.r) begin bad++; $display("FAIL ignore_r act=%h exp=%h", remainder, e.r); end
    total++; if (flags !== e.f) begin bad++; $display("FAIL ignore_flags act=%b exp=%b", flags, e.f); end
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL ignore_extra_done act=%0d exp=0", pulses); end
  endtask

  task automatic test_reset_mid;
    int n, pulses; bit ok; exp_t e;
    pulses = 0;
    launch(32'd12345, 32'd11, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, quotient, remainder, flags} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs act=%h exp=0", {busy, done, quotient, remainder, flags});
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL midreset_done act=%0d exp=0", pulses); end
    launch(32'd9, 32'd3, 1'b0, 1'b1);
    wait_done(60, n, ok);
    e = sb.pop_front();
    total++; if (!ok || n !== e.lat) begin bad++; $display("FAIL midreset_lat act=%0d exp=%0d", n, e.lat); end
    total++; if (quotient !== e.q) begin bad++; $display("FAIL midreset_q act=%h exp=%h", quotient, e.q); end
    total++; if (remainder !== e.r) begin bad++; $display("FAIL midreset_r act=%h exp=%h", remainder, e.r); end
    total++; if (flags !== e.f) begin bad++; $display("FAIL midreset_flags act=%b exp=%b", flags, e.f); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_overflow;
    test_ignore_start;
    test_reset_mid;
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_left act=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
